order_ingress_sequencer: RTL and testbench

- Upstream driver of the order book engine: buffers incoming orders and issues them one at a time over the engine's valid/busy handshake.
- Tallies the trades each order generates and emits one completion record per order.
- Sits between the host/packet-parser order stream and order_book_top; replaces the bench-style "wait idle, pulse valid, wait busy, wait idle" sequence with synthesizable RTL.

---
 rtl/order_ingress_sequencer_pkg.sv | 39 +++
 rtl/order_ingress_sequencer_fifo.sv | 59 +++++
 rtl/order_ingress_sequencer.sv | 148 ++++++++++++++
 tb/tb_order_ingress_sequencer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/order_ingress_sequencer_pkg.sv
// Shared definitions for the order ingress sequencer.
//   - Order word layout {price[31:16], id[15], qty[14:0]} and field accessors.
//   - Completion counter widths.
//   - Sequencer FSM state encoding, also exported on the debug port.
package order_ingress_sequencer_pkg;

  localparam int ORDER_W   = 32;
  localparam int ENTRY_W   = ORDER_W + 1;  // {is_buy, order word}
  localparam int PRICE_MSB = 31;
  localparam int PRICE_LSB = 16;
  localparam int ID_BIT    = 15;
  localparam int QTY_MSB   = 14;
  localparam int QTY_LSB   = 0;
  localparam int PRICE_W   = PRICE_MSB - PRICE_LSB + 1;
  localparam int QTY_W     = QTY_MSB - QTY_LSB + 1;
  localparam int TRADES_W  = 8;
  localparam int FILL_W    = 16;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_ACK  = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_REPORT    = 3'd4
  } seq_state_t;

  function automatic logic [PRICE_W-1:0] price_of(input logic [ORDER_W-1:0] w);
    return w[PRICE_MSB:PRICE_LSB];
  endfunction

  function automatic logic id_of(input logic [ORDER_W-1:0] w);
    return w[ID_BIT];
  endfunction

  function automatic logic [QTY_W-1:0] qty_of(input logic [ORDER_W-1:0] w);
    return w[QTY_MSB:QTY_LSB];
  endfunction

endpackage

// File: rtl/order_ingress_sequencer_fifo.sv
// Synchronous FIFO holding {is_buy, order word} entries.
// Ports:
//   clk, rst          clock, synchronous active-high reset (empties FIFO)
//   push, wdata       write request; ignored when full (no bypass)
//   pop, rdata        read request; rdata is the current head (show-ahead)
//   count, full, empty occupancy status
module order_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 33
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/order_ingress_sequencer.sv
// Buffers upstream orders and issues them one at a time to the order book
// engine, tallying the trades each order produces into one completion record.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   s_valid/s_ready/s_is_buy/s_data   upstream order stream
//   eng_valid/eng_is_buy/eng_data     issue strobe and held order to engine
//   eng_busy                  engine busy flag (acknowledge + completion)
//   trade_valid/trade_info    engine trade strobe, qty in trade_info[14:0]
//   done_valid/done_trades/done_fill_qty/done_timeout  completion record
//   fifo_count                buffered order count
//   state_dbg                 current FSM state
//
// Handshake: an upstream order transfers on a rising clk edge where
// s_valid && s_ready; s_ready depends only on FIFO fullness (and reset), never
// on s_valid. The engine side is strobe-based: eng_valid is a one-cycle pulse
// and the engine acknowledges by raising eng_busy, completing when it drops.
module order_ingress_sequencer
  import order_ingress_sequencer_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic                          s_is_buy,
  input  logic [ORDER_W-1:0]            s_data,
  output logic                          eng_valid,
  output logic                          eng_is_buy,
  output logic [ORDER_W-1:0]            eng_data,
  input  logic                          eng_busy,
  input  logic                          trade_valid,
  input  logic [31:0]                   trade_info,
  output logic                          done_valid,
  output logic [TRADES_W-1:0]           done_trades,
  output logic [FILL_W-1:0]             done_fill_qty,
  output logic                          done_timeout,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output seq_state_t                    state_dbg
);

  localparam int TW = $clog2(ACK_TIMEOUT) + 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(ACK_TIMEOUT - 1);

  seq_state_t           state;
  seq_state_t           next_state;
  logic [ENTRY_W-1:0]   fifo_rdata;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 fifo_pop;
  logic [TW-1:0]        ack_timer;
  logic [TRADES_W-1:0]  acc_trades;
  logic [FILL_W-1:0]    acc_fill;
  logic [TRADES_W-1:0]  trades_nxt;
  logic [FILL_W-1:0]    fill_nxt;
  logic [FILL_W:0]      fill_sum;
  logic                 timeout_nxt;
  logic                 attributable;
  logic                 unused_trade_bits;

  assign unused_trade_bits = ^trade_info[31:QTY_W];

  assign s_ready   = !rst && !fifo_full;
  assign fifo_pop  = (state == ST_ISSUE);
  assign state_dbg = state;

  order_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (s_valid && s_ready),
    .wdata ({s_is_buy, s_data}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:      if (!fifo_empty && !eng_busy) next_state = ST_ISSUE;
      ST_ISSUE:     next_state = ST_WAIT_ACK;
      ST_WAIT_ACK: begin
        if (eng_busy)                     next_state = ST_WAIT_DONE;
        else if (ack_timer == TIMER_LAST) next_state = ST_REPORT;
      end
      ST_WAIT_DONE: if (!eng_busy) next_state = ST_REPORT;
      ST_REPORT:    next_state = ST_IDLE;
      default:      next_state = ST_IDLE;
    endcase
  end

  // Accumulators restart in ISSUE, but a trade arriving in that same cycle
  // already belongs to the new order, so clearing and counting are merged.
  always_comb begin
    attributable = (state == ST_ISSUE) || (state == ST_WAIT_ACK) ||
                   (state == ST_WAIT_DONE);
    trades_nxt   = (state == ST_ISSUE) ? '0 : acc_trades;
    fill_nxt     = (state == ST_ISSUE) ? '0 : acc_fill;
    fill_sum     = {1'b0, fill_nxt} + (FILL_W+1)'(trade_info[QTY_MSB:QTY_LSB]);
    if (trade_valid && attributable) begin
      if (trades_nxt != '1) trades_nxt = trades_nxt + 1'b1;
      fill_nxt = fill_sum[FILL_W] ? '1 : fill_sum[FILL_W-1:0];
    end
    timeout_nxt = (state == ST_WAIT_ACK) && !eng_busy && (ack_timer == TIMER_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      eng_valid     <= 1'b0;
      eng_is_buy    <= 1'b0;
      eng_data      <= '0;
      ack_timer     <= '0;
      acc_trades    <= '0;
      acc_fill      <= '0;
      done_valid    <= 1'b0;
      done_trades   <= '0;
      done_fill_qty <= '0;
      done_timeout  <= 1'b0;
    end else begin
      state     <= next_state;
      eng_valid <= (next_state == ST_ISSUE);
      if (next_state == ST_ISSUE) begin
        {eng_is_buy, eng_data} <= fifo_rdata;
      end
      if (state == ST_ISSUE)         ack_timer <= '0;
      else if (state == ST_WAIT_ACK) ack_timer <= ack_timer + 1'b1;
      if (attributable) begin
        acc_trades <= trades_nxt;
        acc_fill   <= fill_nxt;
      end
      // The record is latched on REPORT entry so it includes that cycle's trade.
      done_valid <= (next_state == ST_REPORT);
      if (next_state == ST_REPORT) begin
        done_trades   <= trades_nxt;
        done_fill_qty <= fill_nxt;
        done_timeout  <= timeout_nxt;
      end
    end
  end

endmodule

// File: tb/tb_order_ingress_sequencer.sv
module tb_order_ingress_sequencer;
  import order_ingress_sequencer_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        s_valid = 1'b0;
  logic        s_ready;
  logic        s_is_buy = 1'b0;
  logic [31:0] s_data = '0;
  logic        eng_valid;
  logic        eng_is_buy;
  logic [31:0] eng_data;
  logic        eng_busy;
  logic        trade_valid = 1'b0;
  logic [31:0] trade_info = '0;
  logic        done_valid;
  logic [7:0]  done_trades;
  logic [15:0] done_fill_qty;
  logic        done_timeout;
  logic [3:0]  fifo_count;
  seq_state_t  state_dbg;

  order_ingress_sequencer #(.FIFO_DEPTH(8), .ACK_TIMEOUT(64)) dut (
    .clk           (clk),
    .rst           (rst),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_is_buy      (s_is_buy),
    .s_data        (s_data),
    .eng_valid     (eng_valid),
    .eng_is_buy    (eng_is_buy),
    .eng_data      (eng_data),
    .eng_busy      (eng_busy),
    .trade_valid   (trade_valid),
    .trade_info    (trade_info),
    .done_valid    (done_valid),
    .done_trades   (done_trades),
    .done_fill_qty (done_fill_qty),
    .done_timeout  (done_timeout),
    .fifo_count    (fifo_count),
    .state_dbg     (state_dbg)
  );

  // ---------------- engine model ----------------
  // Busy rises the cycle after eng_valid and stays up for busy_len cycles.
  logic force_busy = 1'b0;
  logic no_ack     = 1'b0;
  int   busy_len   = 4;
  int   busy_cnt   = 0;

  always @(posedge clk) begin
    if (rst)                       busy_cnt <= 0;
    else if (eng_valid && !no_ack) busy_cnt <= busy_len;
    else if (busy_cnt != 0)        busy_cnt <= busy_cnt - 1;
  end
  assign eng_busy = force_busy || (busy_cnt != 0);

  // ---------------- scoreboard ----------------
  logic [32:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int issue_cnt = 0;
  int done_cnt  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (eng_valid) begin
        issue_cnt++;
        check("issue_pending", 64'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) check("issue_order", {eng_is_buy, eng_data}, exp_q.pop_front());
      end
      if (done_valid) done_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push(input logic is_buy, input logic [31:0] data, output logic accepted);
    @(negedge clk);
    s_valid  = 1'b1;
    s_is_buy = is_buy;
    s_data   = data;
    accepted = s_ready;
    if (accepted) exp_q.push_back({is_buy, data});
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic wait_issue(output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!eng_valid && cycles < 200);
    check("issue_seen", eng_valid, 1);
  endtask

  task automatic wait_done(input int budget, output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!done_valid && cycles < budget);
    check("done_seen", done_valid, 1);
  endtask

  task automatic drive_trades(input int n, input logic [14:0] qty);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      trade_valid = 1'b1;
      trade_info  = {17'h0, qty};
    end
    @(negedge clk);
    trade_valid = 1'b0;
    trade_info  = '0;
  endtask

  // ---------------- directed tests ----------------
  initial begin
    logic acc;
    int   lat;
    int   d;
    int   base_issue;
    int   base_done;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_eng_valid", eng_valid, 0);
    check("rst_eng_data", eng_data, 0);
    check("rst_eng_is_buy", eng_is_buy, 0);
    check("rst_done_valid", done_valid, 0);
    check("rst_done_trades", done_trades, 0);
    check("rst_done_fill", done_fill_qty, 0);
    check("rst_done_timeout", done_timeout, 0);
    check("rst_fifo_count", fifo_count, 0);
    check("rst_s_ready_low", s_ready, 0);
    check("rst_state", state_dbg, ST_IDLE);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_s_ready", s_ready, 1);

    // Single sell order {105,1,50}, no trades
    push(1'b0, 32'h0069_8032, acc);
    check("t1_accepted", acc, 1);
    wait_issue(lat);
    check("t1_latency", lat, 2);
    check("t1_eng_data", eng_data, 32'h0069_8032);
    check("t1_eng_is_buy", eng_is_buy, 0);
    wait_done(100, d);
    check("t1_done_delay", d, 6);
    check("t1_trades", done_trades, 0);
    check("t1_fill", done_fill_qty, 0);
    check("t1_timeout", done_timeout, 0);

    // Buy {110,1,100} with trades 20, 50, 10
    busy_len = 10;
    push(1'b1, 32'h006E_8064, acc);
    check("t2_accepted", acc, 1);
    wait_issue(lat);
    check("t2_eng_is_buy", eng_is_buy, 1);
    drive_trades(1, 15'd20);
    drive_trades(1, 15'd50);
    drive_trades(1, 15'd10);
    wait_done(100, d);
    check("t2_trades", done_trades, 3);
    check("t2_fill", done_fill_qty, 80);
    check("t2_timeout", done_timeout, 0);

    // FIFO full with engine held busy, then drain in order
    busy_len   = 4;
    force_busy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      push(i[0], {16'(100 + i), 1'b0, 15'(i + 1)}, acc);
      check("t3_accepted", acc, 1);
    end
    check("t3_count_full", fifo_count, 8);
    check("t3_s_ready_full", s_ready, 0);
    push(1'b1, 32'hDEAD_0001, acc);
    check("t3_ninth_refused", acc, 0);
    check("t3_count_hold", fifo_count, 8);
    base_issue = issue_cnt;
    base_done  = done_cnt;
    @(negedge clk);
    force_busy = 1'b0;
    for (int c = 0; c < 300 && done_cnt < base_done + 8; c++) @(negedge clk);
    repeat (4) @(negedge clk);
    check("t3_done_count", done_cnt - base_done, 8);
    check("t3_issue_count", issue_cnt - base_issue, 8);
    check("t3_exp_empty", exp_q.size(), 0);
    check("t3_count_drained", fifo_count, 0);

    // Ack timeout, then normal order
    no_ack = 1'b1;
    push(1'b0, 32'h0050_0007, acc);
    wait_issue(lat);
    wait_done(200, d);
    check("t4_timeout_delay", d, 65);
    check("t4_timeout_flag", done_timeout, 1);
    check("t4_timeout_trades", done_trades, 0);
    no_ack = 1'b0;
    push(1'b1, 32'h0051_8009, acc);
    wait_issue(lat);
    check("t4_next_latency", lat, 2);
    wait_done(100, d);
    check("t4_next_delay", d, 6);
    check("t4_next_timeout", done_timeout, 0);

    // Reset during WAIT_DONE with 3 orders buffered
    busy_len = 30;
    push(1'b0, 32'h0060_0001, acc);
    wait_issue(lat);
    push(1'b0, 32'h0061_0002, acc);
    push(1'b1, 32'h0062_0003, acc);
    push(1'b0, 32'h0063_0004, acc);
    check("t5_buffered", fifo_count, 3);
    check("t5_state", state_dbg, ST_WAIT_DONE);
    base_issue = issue_cnt;
    base_done  = done_cnt;
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("t5_rst_eng_valid", eng_valid, 0);
    check("t5_rst_count", fifo_count, 0);
    check("t5_rst_done_valid", done_valid, 0);
    check("t5_rst_s_ready", s_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    check("t5_s_ready_after", s_ready, 1);
    repeat (40) @(negedge clk);
    check("t5_no_done", done_cnt - base_done, 0);
    check("t5_no_issue", issue_cnt - base_issue, 0);

    // Saturation: 300 trades of qty 32767
    busy_len = 320;
    push(1'b1, 32'h0070_FFFF, acc);
    wait_issue(lat);
    drive_trades(300, 15'h7FFF);
    wait_done(100, d);
    check("t6_trades_sat", done_trades, 255);
    check("t6_fill_sat", done_fill_qty, 16'hFFFF);
    check("t6_timeout", done_timeout, 0);
    repeat (3) @(negedge clk);
    check("final_count", fifo_count, 0);
    check("final_exp_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
